// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative M-extension unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues requests and consumes results.
  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  // Unit side.
  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, flush_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, sign fix-up folded into the last step.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        op_q;
  logic              flip_q;
  logic              rem_neg_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quot, rem, final_res;

  assign accept       = (state_q == S_IDLE) && bus.valid_i && !bus.flush_i;
  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.result_o = result_q;

  // Decode request: operand signedness, magnitudes and early-out division cases.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (bus.funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010:  signed_a = 1'b1;
      default: ;
    endcase
    sign_a   = signed_a && bus.op_a_i[XLEN-1];
    sign_b   = signed_b && bus.op_b_i[XLEN-1];
    mag_a    = sign_a ? -bus.op_a_i : bus.op_a_i;
    mag_b    = sign_b ? -bus.op_b_i : bus.op_b_i;
    div_zero = bus.funct3_i[2] && (bus.op_b_i == '0);
    div_ovf  = bus.funct3_i[2] && signed_b &&
               (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
    else          special_res = bus.funct3_i[1] ? '0 : bus.op_a_i;
  end

  // One iteration step plus the signed result that step would produce if final.
  // acc_q holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (op_q[2]) acc_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else         acc_next = {mul_sum, acc_q[XLEN-1:1]};
    prod = flip_q ? -acc_next : acc_next;
    quot = flip_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = rem_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         final_res = prod[XLEN-1:0];
      3'b100, 3'b101: final_res = quot;
      3'b110, 3'b111: final_res = rem;
      default:        final_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.valid_i) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (count_q == '0) state_d = S_DONE;
        S_DONE:  if (bus.ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: latch on accept, iterate in CALC, register the result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      flip_q    <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else if (bus.flush_i) begin
      count_q <= '0;
    end else if (accept) begin
      op_q      <= bus.funct3_i;
      flip_q    <= sign_a ^ sign_b;
      rem_neg_q <= sign_a;
      opnd_q    <= bus.funct3_i[2] ? mag_b : mag_a;
      acc_q     <= {{XLEN{1'b0}}, (bus.funct3_i[2] ? mag_a : mag_b)};
      count_q   <= special ? '0 : CNT_W'(XLEN - 1);
      if (special) result_q <= special_res;
    end else if (state_q == S_CALC) begin
      acc_q   <= acc_next;
      count_q <= count_q - 1'b1;
      if (count_q == '0) result_q <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   npass = 0;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural result of an M-extension op, straight from the ISA rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    int ia, ib;
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin pu = ua * ub; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns 1 ns after the acceptance edge with inputs scrambled.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!bus.ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", bus.ready_o, 1);
    bus.valid_i  = 1'b1;
    bus.funct3_i = f;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b0;
    bus.funct3_i = 3'($urandom);
    bus.op_a_i   = $urandom;
    bus.op_b_i   = $urandom;
  endtask

  // Waits for the result, checks latency/value/stability, then completes the handshake.
  task automatic finish_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
    logic [31:0] exp = ref_model(f, a, b);
    int exp_lat = is_special(f, a, b) ? 0 : XLEN;
    int lat = 0;
    @(negedge clk);
    check("busy_ready", bus.ready_o, 0);
    while (!bus.valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check(tag, bus.result_o, exp);
    check("ready_in_done", bus.ready_o, 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.valid_o, 1);
      check("hold_result", bus.result_o, exp);
      check("hold_ready", bus.ready_o, 0);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    check("post_hs_valid", bus.valid_o, 0);
    check("post_hs_ready", bus.ready_o, 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    start_op(f, a, b);
    finish_op(tag, f, a, b, hold);
  endtask

  initial begin
    int seen;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    bus.valid_i  = 1'b0;
    bus.funct3_i = 3'b000;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;
    bus.flush_i  = 1'b0;
    bus.ready_i  = 1'b0;

    #12;
    check("rst_ready", bus.ready_o, 1);
    check("rst_valid", bus.valid_o, 0);
    check("rst_result", bus.result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu_min", 3'b011, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 0);
    run_op("divu_zero", 3'b101, 32'd5, 32'd0, 0);
    run_op("rem_zero", 3'b110, 32'd5, 32'd0, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush in the fifth CALC cycle, with a competing request on the same cycle.
    start_op(3'b000, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    bus.flush_i  = 1'b1;
    bus.valid_i  = 1'b1;
    bus.funct3_i = 3'b101;
    bus.op_a_i   = 32'd5;
    bus.op_b_i   = 32'd0;
    @(negedge clk);
    check("flush_ready", bus.ready_o, 1);
    check("flush_valid", bus.valid_o, 0);
    // Request during flush while idle must be dropped.
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    check("drop_ready", bus.ready_o, 1);
    check("drop_valid", bus.valid_o, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) seen++;
    end
    check("flush_no_valid", 64'(seen), 0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 0);

    run_op("hold3_mul", 3'b000, 32'd1234, 32'd5678, 3);

    // Asynchronous reset in the middle of CALC.
    start_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_calc_valid", bus.valid_o, 0);
    check("arst_calc_ready", bus.ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is being presented.
    start_op(3'b101, 32'd9, 32'd0);
    @(negedge clk);
    check("pre_arst_valid", bus.valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done_valid", bus.valid_o, 0);
    check("arst_done_ready", bus.ready_o, 1);
    check("arst_done_result", bus.result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mulh_after_rst", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      run_op("rand", rf, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
